// File: rtl/bcd_event_counter_if.sv
// Button/display path bundle: debounced levels and clear in,
// packed BCD count with step/wrap pulses out.
interface bcd_event_counter_if;
    logic [1:0]  db_level_amisha;
    logic        clr_amisha;
    logic [15:0] bcd_amisha;
    logic        step_amisha;
    logic        ovf_amisha;

    modport master (
        output db_level_amisha,
        output clr_amisha,
        input  bcd_amisha,
        input  step_amisha,
        input  ovf_amisha
    );

    modport slave (
        input  db_level_amisha,
        input  clr_amisha,
        output bcd_amisha,
        output step_amisha,
        output ovf_amisha
    );
endinterface

// File: rtl/bcd_event_counter.sv
// Four-digit BCD up/down counter driven by debounced buttons,
// with press edge detection and hold-to-repeat stepping.
module bcd_event_counter #(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic               clk_amisha,
    input  logic               reset_amisha,
    bcd_event_counter_if.slave bus
);

    localparam int MAX_P = (REPEAT_DELAY > REPEAT_RATE) ?
                           REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = $clog2(MAX_P) + 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_e;

    state_e      state_q, state_d;
    logic        dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]  prev_q, prev_d;
    logic [15:0] bcd_q, bcd_d;
    logic        step_q, step_d;
    logic        ovf_q, ovf_d;

    logic [1:0]  lvl;
    logic [1:0]  rise;
    logic        do_step;
    logic        step_dir;
    logic        held;
    logic        other;
    logic [TW-1:0] limit;
    logic [15:0] bcd_next;
    logic        carry;
    logic [3:0]  dig;

    assign lvl  = bus.db_level_amisha;
    assign rise = lvl & ~prev_q;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        do_step  = 1'b0;
        step_dir = dir_q;
        held     = lvl[dir_q];
        other    = lvl[~dir_q];
        limit    = (state_q == HOLD) ? TW'(REPEAT_DELAY) : TW'(REPEAT_RATE);
        unique case (state_q)
            IDLE: begin
                if (rise == 2'b01 && !lvl[1]) begin
                    do_step  = 1'b1;
                    step_dir = 1'b0;
                    dir_d    = 1'b0;
                    timer_d  = TW'(1);
                    state_d  = HOLD;
                end else if (rise == 2'b10 && !lvl[0]) begin
                    do_step  = 1'b1;
                    step_dir = 1'b1;
                    dir_d    = 1'b1;
                    timer_d  = TW'(1);
                    state_d  = HOLD;
                end else if (&lvl) begin
                    state_d = LOCK;
                end
            end
            HOLD, REPEAT: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (other) begin
                    state_d = LOCK;
                end else if (timer_q == limit) begin
                    do_step = 1'b1;
                    timer_d = TW'(1);
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOCK: begin
                if (lvl == 2'b00) state_d = IDLE;
            end
            default: state_d = LOCK;
        endcase
    end

    // Ripple carry/borrow: carry stays set only while digits wrap.
    always_comb begin
        bcd_next = bcd_q;
        carry    = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < 4; i++) begin
            dig = bcd_q[i*4 +: 4];
            if (carry) begin
                if (!step_dir) begin
                    if (dig == 4'd9) begin
                        bcd_next[i*4 +: 4] = 4'd0;
                    end else begin
                        bcd_next[i*4 +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        bcd_next[i*4 +: 4] = 4'd9;
                    end else begin
                        bcd_next[i*4 +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        prev_d = lvl;
        bcd_d  = do_step ? bcd_next : bcd_q;
        step_d = do_step;
        ovf_d  = do_step & carry;
        if (bus.clr_amisha) begin
            bcd_d   = 16'h0000;
            step_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            state_q <= LOCK;
            dir_q   <= 1'b0;
            timer_q <= '0;
            prev_q  <= 2'b00;
            bcd_q   <= 16'h0000;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= bus.clr_amisha ? LOCK : state_d;
            dir_q   <= dir_d;
            timer_q <= bus.clr_amisha ? '0 : timer_d;
            prev_q  <= prev_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.bcd_amisha  = bcd_q;
    assign bus.step_amisha = step_q;
    assign bus.ovf_amisha  = ovf_q;

endmodule
